// File: rtl/el2_dec_trigger_csr_pkg.sv
// Purpose: shared types and constants for the debug-trigger CSR block.
//   - CSR addresses for tselect/tdata1/tdata2
//   - mcontrol (tdata1) bit positions and read-only field values
//   - el2_trigger_pkt_t, the per-trigger packet sent to the matchers
//   - mcontrol_t, the writable tdata1 state of one trigger, and its read formatter
package el2_dec_trigger_csr_pkg;

  localparam int unsigned NUM_TRIG = 4;
  localparam int unsigned TSEL_W   = 2;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned CSR_AW   = 12;

  localparam logic [CSR_AW-1:0] CSR_TSELECT = 12'h7A0;
  localparam logic [CSR_AW-1:0] CSR_TDATA1  = 12'h7A1;
  localparam logic [CSR_AW-1:0] CSR_TDATA2  = 12'h7A2;

  // mcontrol field positions
  localparam int unsigned MC_TYPE_LSB    = 28;
  localparam int unsigned MC_DMODE       = 27;
  localparam int unsigned MC_MASKMAX_LSB = 21;
  localparam int unsigned MC_HIT         = 20;
  localparam int unsigned MC_SELECT      = 19;
  localparam int unsigned MC_ACTION      = 12;
  localparam int unsigned MC_CHAIN       = 11;
  localparam int unsigned MC_MATCH       = 7;
  localparam int unsigned MC_M           = 6;
  localparam int unsigned MC_EXECUTE     = 2;
  localparam int unsigned MC_STORE       = 1;
  localparam int unsigned MC_LOAD        = 0;

  localparam logic [3:0] MC_TYPE_VAL    = 4'd2;
  localparam logic [5:0] MC_MASKMAX_VAL = 6'h1F;

  typedef struct packed {
    logic            select;
    logic            match;
    logic            store;
    logic            load;
    logic            execute;
    logic            m;
    logic [XLEN-1:0] tdata2;
  } el2_trigger_pkt_t;

  typedef struct packed {
    logic dmode;
    logic hit;
    logic select;
    logic action;
    logic chain;
    logic match;
    logic m;
    logic execute;
    logic store;
    logic load;
  } mcontrol_t;

  // Build the architectural tdata1 read value from stored state.
  function automatic logic [XLEN-1:0] mcontrol_rd(input mcontrol_t mc);
    logic [XLEN-1:0] rd;
    rd = '0;
    rd[MC_TYPE_LSB +: 4]    = MC_TYPE_VAL;
    rd[MC_DMODE]            = mc.dmode;
    rd[MC_MASKMAX_LSB +: 6] = MC_MASKMAX_VAL;
    rd[MC_HIT]              = mc.hit;
    rd[MC_SELECT]           = mc.select;
    rd[MC_ACTION]           = mc.action;
    rd[MC_CHAIN]            = mc.chain;
    rd[MC_MATCH]            = mc.match;
    rd[MC_M]                = mc.m;
    rd[MC_EXECUTE]          = mc.execute;
    rd[MC_STORE]            = mc.store;
    rd[MC_LOAD]             = mc.load;
    return rd;
  endfunction

endpackage

// File: rtl/el2_dec_trigger_csr_if.sv
// Purpose: CSR access bus between the TLU (master) and the trigger CSR block (slave).
//   csr_wr_en/addr/data : single-cycle write strobe with RMW-resolved data
//   csr_rd_addr         : read address
//   csr_rd_data/hit     : combinational read return and address-hit flag
interface el2_dec_trigger_csr_if
  import el2_dec_trigger_csr_pkg::*;
();

  logic              csr_wr_en;
  logic [CSR_AW-1:0] csr_wr_addr;
  logic [XLEN-1:0]   csr_wr_data;
  logic [CSR_AW-1:0] csr_rd_addr;
  logic [XLEN-1:0]   csr_rd_data;
  logic              csr_rd_hit;

  modport master (
    output csr_wr_en, csr_wr_addr, csr_wr_data, csr_rd_addr,
    input  csr_rd_data, csr_rd_hit
  );

  modport slave (
    input  csr_wr_en, csr_wr_addr, csr_wr_data, csr_rd_addr,
    output csr_rd_data, csr_rd_hit
  );

endinterface

// File: rtl/el2_trigger_reg.sv
// Purpose: one debug trigger's tdata1 (mcontrol) and tdata2 state.
//   clk, rst        : clock, async active-high reset
//   dbg_mode        : core in debug mode (unlocks dmode triggers and dmode writes)
//   wr_tdata1/2     : write strobes already qualified by address and tselect
//   wr_data         : CSR write data
//   chain_wr_ok     : this trigger owns a chain bit (lower member of a pair)
//   next_dmode      : dmode of the partner trigger above this one
//   fire            : this trigger fired this cycle (sets hit)
//   mc, tdata2      : stored state
module el2_trigger_reg
  import el2_dec_trigger_csr_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            dbg_mode,
  input  logic            wr_tdata1,
  input  logic            wr_tdata2,
  input  logic [XLEN-1:0] wr_data,
  input  logic            chain_wr_ok,
  input  logic            next_dmode,
  input  logic            fire,
  output mcontrol_t       mc,
  output logic [XLEN-1:0] tdata2
);

  mcontrol_t       mc_d, mc_q;
  logic [XLEN-1:0] tdata2_d, tdata2_q;
  logic            wr_ok;
  logic            chain_lock;

  // Write qualification, WARL field rules and hit set
  always_comb begin
    mc_d       = mc_q;
    tdata2_d   = tdata2_q;
    // A dmode trigger is owned by the debugger; machine mode cannot touch it.
    wr_ok      = ~(mc_q.dmode & ~dbg_mode);
    // Chaining into a debugger-owned partner would let M-mode alter its behaviour.
    chain_lock = wr_data[MC_CHAIN] & next_dmode & ~dbg_mode;

    if (fire) mc_d.hit = 1'b1;

    if (wr_tdata1 && wr_ok) begin
      mc_d.dmode   = dbg_mode & wr_data[MC_DMODE];
      mc_d.hit     = wr_data[MC_HIT];
      mc_d.select  = wr_data[MC_SELECT];
      mc_d.action  = wr_data[MC_ACTION] & mc_d.dmode;
      mc_d.chain   = chain_wr_ok & (chain_lock ? mc_q.chain : wr_data[MC_CHAIN]);
      mc_d.match   = wr_data[MC_MATCH];
      mc_d.m       = wr_data[MC_M];
      mc_d.execute = wr_data[MC_EXECUTE];
      mc_d.store   = wr_data[MC_STORE];
      mc_d.load    = wr_data[MC_LOAD];
    end

    if (wr_tdata2 && wr_ok) tdata2_d = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_q     <= '0;
      tdata2_q <= '0;
    end else begin
      mc_q     <= mc_d;
      tdata2_q <= tdata2_d;
    end
  end

  assign mc     = mc_q;
  assign tdata2 = tdata2_q;

endmodule

// File: rtl/el2_dec_trigger_csr.sv
// Purpose: debug trigger CSRs (tselect/tdata1/tdata2), trigger packets to the
// matchers, and commit-time fire resolution with chaining.
//   clk, rst        : clock, async active-high reset
//   csr             : CSR read/write bus (slave side)
//   dbg_mode        : core in debug mode; suppresses firing
//   trig_match_r    : raw per-trigger matches at commit
//   trig_valid_r    : commit-stage instruction valid
//   trigger_pkt_any : per-trigger match configuration, decoded from registers
//   trig_fire_r     : registered chain-resolved fire vector
//   trig_enter_dbg  : registered, some fired trigger requests debug entry
//   trig_ebreak     : registered, some fired trigger requests a breakpoint
module el2_dec_trigger_csr
  import el2_dec_trigger_csr_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  el2_dec_trigger_csr_if.slave            csr,
  input  logic                            dbg_mode,
  input  logic [NUM_TRIG-1:0]             trig_match_r,
  input  logic                            trig_valid_r,
  output el2_trigger_pkt_t [NUM_TRIG-1:0] trigger_pkt_any,
  output logic [NUM_TRIG-1:0]             trig_fire_r,
  output logic                            trig_enter_dbg,
  output logic                            trig_ebreak
);

  // Lower member of each pair (0 and 2) carries the chain bit.
  localparam logic [NUM_TRIG-1:0] CHAIN_WR_OK = 4'b0101;

  logic [TSEL_W-1:0]   tsel_d, tsel_q;
  logic [NUM_TRIG-1:0] fire_d, fire_q;
  logic                enter_dbg_d, enter_dbg_q;
  logic                ebreak_d, ebreak_q;

  mcontrol_t [NUM_TRIG-1:0] mc;
  logic [XLEN-1:0]          tdata2 [NUM_TRIG];
  logic [NUM_TRIG-1:0]      wr_t1, wr_t2;
  logic [NUM_TRIG-1:0]      next_dmode;
  logic [NUM_TRIG-1:0]      action;
  logic [NUM_TRIG-1:0]      m;
  logic [NUM_TRIG-1:0]      fire;

  // Write decode; tdata1/tdata2 writes target the selected trigger only
  always_comb begin
    tsel_d = tsel_q;
    wr_t1  = '0;
    wr_t2  = '0;
    if (csr.csr_wr_en && csr.csr_wr_addr == CSR_TSELECT) tsel_d = csr.csr_wr_data[TSEL_W-1:0];
    for (int i = 0; i < NUM_TRIG; i++) begin
      wr_t1[i] = csr.csr_wr_en && (csr.csr_wr_addr == CSR_TDATA1) && (tsel_q == TSEL_W'(i));
      wr_t2[i] = csr.csr_wr_en && (csr.csr_wr_addr == CSR_TDATA2) && (tsel_q == TSEL_W'(i));
    end
  end

  // Partner dmode used to lock chain writes on the lower pair member
  always_comb begin
    next_dmode    = '0;
    next_dmode[0] = mc[1].dmode;
    next_dmode[2] = mc[3].dmode;
  end

  for (genvar i = 0; i < NUM_TRIG; i++) begin : g_trig
    el2_trigger_reg u_trig (
      .clk         (clk),
      .rst         (rst),
      .dbg_mode    (dbg_mode),
      .wr_tdata1   (wr_t1[i]),
      .wr_tdata2   (wr_t2[i]),
      .wr_data     (csr.csr_wr_data),
      .chain_wr_ok (CHAIN_WR_OK[i]),
      .next_dmode  (next_dmode[i]),
      .fire        (fire[i]),
      .mc          (mc[i]),
      .tdata2      (tdata2[i])
    );
  end

  // Chain resolution: a chained pair fires only when both members match
  always_comb begin
    m       = trig_match_r & {NUM_TRIG{trig_valid_r & ~dbg_mode}};
    fire[0] = m[0] & (~mc[0].chain | m[1]);
    fire[1] = m[1] & (~mc[0].chain | m[0]);
    fire[2] = m[2] & (~mc[2].chain | m[3]);
    fire[3] = m[3] & (~mc[2].chain | m[2]);
    for (int i = 0; i < NUM_TRIG; i++) action[i] = mc[i].action;
    fire_d      = fire;
    enter_dbg_d = |(fire & action);
    ebreak_d    = |(fire & ~action);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tsel_q      <= '0;
      fire_q      <= '0;
      enter_dbg_q <= 1'b0;
      ebreak_q    <= 1'b0;
    end else begin
      tsel_q      <= tsel_d;
      fire_q      <= fire_d;
      enter_dbg_q <= enter_dbg_d;
      ebreak_q    <= ebreak_d;
    end
  end

  assign trig_fire_r    = fire_q;
  assign trig_enter_dbg = enter_dbg_q;
  assign trig_ebreak    = ebreak_q;

  // Packets are a direct view of register state
  always_comb begin
    for (int i = 0; i < NUM_TRIG; i++) begin
      trigger_pkt_any[i].select  = mc[i].select;
      trigger_pkt_any[i].match   = mc[i].match;
      trigger_pkt_any[i].store   = mc[i].store;
      trigger_pkt_any[i].load    = mc[i].load;
      trigger_pkt_any[i].execute = mc[i].execute;
      trigger_pkt_any[i].m       = mc[i].m;
      trigger_pkt_any[i].tdata2  = tdata2[i];
    end
  end

  // Combinational read mux
  always_comb begin
    csr.csr_rd_data = '0;
    csr.csr_rd_hit  = 1'b0;
    unique case (csr.csr_rd_addr)
      CSR_TSELECT: begin
        csr.csr_rd_data = XLEN'(tsel_q);
        csr.csr_rd_hit  = 1'b1;
      end
      CSR_TDATA1: begin
        csr.csr_rd_data = mcontrol_rd(mc[tsel_q]);
        csr.csr_rd_hit  = 1'b1;
      end
      CSR_TDATA2: begin
        csr.csr_rd_data = tdata2[tsel_q];
        csr.csr_rd_hit  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
